// File: rtl/led_seq_ctrl_if.sv
// rtl/led_seq_ctrl_if.sv - config write port, playback controls and LED status bundle for led_seq_ctrl
interface led_seq_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] led_out;
    logic [2:0] step_idx;
    logic       busy;
    logic       done;

    // Driver side: the ui_in/uio_in decode (or a bench)
    modport master (
        output cfg_valid, cfg_addr, cfg_wdata, start, stop, pause,
        input  cfg_ready, led_out, step_idx, busy, done
    );

    // Sequencer side
    modport slave (
        input  cfg_valid, cfg_addr, cfg_wdata, start, stop, pause,
        output cfg_ready, led_out, step_idx, busy, done
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED pattern sequencer with prescaler, pattern table and run/pause/stop control (optional PWM dimming: LED_SEQ_PWM_EN)
module led_seq_ctrl #(
    parameter int CNT_W     = 26,
    parameter int PAT_DEPTH = 8,
    parameter int RST_RATE  = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    led_seq_ctrl_if.slave  bus
);

    localparam int IDX_W = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] ADDR_RATE = 4'd8;
    localparam logic [3:0] ADDR_CTRL = 4'd9;
`ifdef LED_SEQ_PWM_EN
    localparam logic [3:0] ADDR_BRIGHT = 4'd10;
`endif

    localparam logic [3:0]       PAT_LIMIT = 4'(PAT_DEPTH);
    localparam logic [2:0]       LEN_MAX   = 3'(PAT_DEPTH - 1);
    localparam logic [4:0]       RATE_MAX  = 5'(CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] prescaler;
    logic [CNT_W-1:0] period_max;
    logic [4:0]       rate;
    logic [2:0]       len;
    logic             oneshot;
    logic [7:0]       pat [PAT_DEPTH];
    logic [7:0]       led_pat;
    logic [2:0]       idx;
    logic             done_q;

    logic             idle_like;
    logic             active;
    logic             cfg_ready;
    logic             cfg_fire;
    logic             tick;
    logic             at_last;
    logic [2:0]       idx_inc;
    logic [4:0]       rate_wr;
    logic [2:0]       len_wr;

    // Config is only accepted while nothing is playing, so the table never changes under the sequencer
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign active    = (state == ST_RUN) || (state == ST_PAUSE);
    assign cfg_ready = idle_like;
    assign cfg_fire  = bus.cfg_valid && cfg_ready;

    // Step period is 2^rate cycles: tick on the last count before the prescaler wraps
    assign period_max = (CNT_ONE << rate) - CNT_ONE;
    assign tick       = (prescaler == period_max);
    assign idx_inc    = idx + 3'd1;
    assign at_last    = (idx >= len);

    // Out-of-range values are clamped when written so the live registers are always legal
    assign rate_wr = ({27'd0, bus.cfg_wdata[4:0]} >= CNT_W) ? RATE_MAX : bus.cfg_wdata[4:0];
    assign len_wr  = (bus.cfg_wdata[2:0] > LEN_MAX) ? LEN_MAX : bus.cfg_wdata[2:0];

    // Playback state machine: stop beats start and tick; pause freezes prescaler, index and LEDs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            idx       <= 3'd0;
            led_pat   <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state     <= ST_IDLE;
                prescaler <= '0;
                idx       <= 3'd0;
                led_pat   <= 8'h00;
            end else if (bus.start && idle_like) begin
                // Reads the table as it stood before any write landing on this same edge
                state     <= ST_RUN;
                prescaler <= '0;
                idx       <= 3'd0;
                led_pat   <= pat[0];
            end else if (active) begin
                if (bus.pause) begin
                    state <= ST_PAUSE;
                end else begin
                    state <= ST_RUN;
                    if (tick) begin
                        prescaler <= '0;
                        if (!at_last) begin
                            idx     <= idx_inc;
                            led_pat <= pat[idx_inc[IDX_W-1:0]];
                        end else if (!oneshot) begin
                            idx     <= 3'd0;
                            led_pat <= pat[0];
                        end else begin
                            // One-shot finished: last entry stays lit
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] brightness;
    logic [7:0] pwm_cnt;

    // Free-running PWM phase; LEDs are on while the phase is below the brightness level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else begin
            pwm_cnt <= pwm_cnt + 8'h01;
        end
    end
`endif

    // Register file and pattern table; reset restores the alternating FF/00 blink table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate    <= 5'(RST_RATE);
            len     <= LEN_MAX;
            oneshot <= 1'b0;
            for (int i = 0; i < PAT_DEPTH; i++) begin
                pat[i] <= (i % 2 == 0) ? 8'hFF : 8'h00;
            end
`ifdef LED_SEQ_PWM_EN
            brightness <= 8'hFF;
`endif
        end else if (cfg_fire) begin
            if (bus.cfg_addr < PAT_LIMIT) begin
                pat[bus.cfg_addr[IDX_W-1:0]] <= bus.cfg_wdata;
            end else if (bus.cfg_addr == ADDR_RATE) begin
                rate <= rate_wr;
            end else if (bus.cfg_addr == ADDR_CTRL) begin
                len     <= len_wr;
                oneshot <= bus.cfg_wdata[7];
`ifdef LED_SEQ_PWM_EN
            end else if (bus.cfg_addr == ADDR_BRIGHT) begin
                brightness <= bus.cfg_wdata;
`endif
            end
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.step_idx  = idx;
    assign bus.busy      = active;
    assign bus.done      = done_q;
`ifdef LED_SEQ_PWM_EN
    assign bus.led_out   = led_pat & {8{pwm_cnt < brightness}};
`else
    assign bus.led_out   = led_pat;
`endif

endmodule
